// File: rtl/myfilter_pkg.sv
// Shared types and constants for the I2C receive front end.
//   i2c_rx_state_t  : receive FSM state (IDLE, DATA, ACK)
//   I2C_BYTE_BITS   : data bits per byte
//   SYNC_STAGES_DEF : default synchroniser depth
//   FILT_LEN_DEF    : default deglitch length in clk cycles
package myfilter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ACK
  } i2c_rx_state_t;

  localparam int unsigned I2C_BYTE_BITS   = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILT_LEN_DEF    = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus deglitch filter for one open-drain bus line.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   line_in  : raw pad level, asynchronous to clk
//   line_out : filtered level; moves only after the synchronised value has
//              disagreed with it for FILT_LEN consecutive cycles (reset 1)
module i2c_line_filter
  import myfilter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT_LEN    = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_out
);

  localparam int unsigned CntW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic                   filt_q;
  logic                   line_sync;

  assign line_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Bus idles high, so come out of reset already seeing an idle line.
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      if (line_sync != filt_q) begin
        if (cnt_q == CntW'(FILT_LEN - 1)) begin
          filt_q <= line_sync;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        // Any reversion restarts the stability window.
        cnt_q <= '0;
      end
    end
  end

  assign line_out = filt_q;

endmodule

// File: rtl/i2c_rx_front.sv
// I2C slave receive front end: filters SCL/SDA, detects START/STOP, shifts in
// bytes MSB-first and tracks the 9th-bit ACK slot. All outputs are registered.
//   clk, rst_n          : clock, asynchronous active-low reset
//   scl_in, sda_in      : raw pad levels
//   start_out, stop_out : one-cycle bus condition pulses
//   scl_rise_out/fall   : one-cycle filtered SCL edge pulses
//   byte_out/_valid_out : last completed byte and its update strobe
//   ack_slot_out        : high across the 9th bit period
//   ack_bit_out         : SDA sampled on the 9th rise (0 = ACK)
//   bit_cnt_out         : data bits received in current byte (0..8)
//   busy_out            : bus busy between START and STOP
module i2c_rx_front
  import myfilter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILT_LEN    = FILT_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       start_out,
  output logic       stop_out,
  output logic       scl_rise_out,
  output logic       scl_fall_out,
  output logic [7:0] byte_out,
  output logic       byte_valid_out,
  output logic       ack_slot_out,
  output logic       ack_bit_out,
  output logic [3:0] bit_cnt_out,
  output logic       busy_out
);

  logic scl_f, sda_f;
  logic scl_d_q, sda_d_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_rx_state_t            state_q;
  logic [I2C_BYTE_BITS-1:0] shift_q, byte_q;
  logic [3:0]               bit_cnt_q;
  logic start_q, stop_q, rise_q, fall_q, byte_valid_q, ack_slot_q, ack_bit_q, busy_q;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (scl_in),
    .line_out (scl_f)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (sda_in),
    .line_out (sda_f)
  );

  assign scl_rise  = scl_f & ~scl_d_q;
  assign scl_fall  = ~scl_f & scl_d_q;
  // Requiring SCL high in both cycles rejects SDA moving alongside an SCL edge.
  assign start_det = scl_f & scl_d_q & sda_d_q & ~sda_f;
  assign stop_det  = scl_f & scl_d_q & ~sda_d_q & sda_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d_q      <= 1'b1;
      sda_d_q      <= 1'b1;
      state_q      <= IDLE;
      shift_q      <= '0;
      byte_q       <= '0;
      bit_cnt_q    <= '0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      ack_slot_q   <= 1'b0;
      ack_bit_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      scl_d_q      <= scl_f;
      sda_d_q      <= sda_f;
      start_q      <= start_det;
      stop_q       <= stop_det;
      rise_q       <= scl_rise;
      fall_q       <= scl_fall;
      byte_valid_q <= 1'b0;
      if (start_det) begin
        state_q    <= DATA;
        shift_q    <= '0;
        bit_cnt_q  <= '0;
        busy_q     <= 1'b1;
        ack_slot_q <= 1'b0;
      end else if (stop_det) begin
        state_q    <= IDLE;
        shift_q    <= '0;
        bit_cnt_q  <= '0;
        busy_q     <= 1'b0;
        ack_slot_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          DATA: begin
            if (scl_rise && (bit_cnt_q < 4'(I2C_BYTE_BITS))) begin
              shift_q   <= {shift_q[I2C_BYTE_BITS-2:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'(I2C_BYTE_BITS - 1)) begin
                byte_q       <= {shift_q[I2C_BYTE_BITS-2:0], sda_f};
                byte_valid_q <= 1'b1;
              end
            end else if (scl_fall && (bit_cnt_q == 4'(I2C_BYTE_BITS))) begin
              state_q    <= ACK;
              ack_slot_q <= 1'b1;
            end
          end
          ACK: begin
            if (scl_rise) begin
              ack_bit_q <= sda_f;
            end else if (scl_fall) begin
              state_q    <= DATA;
              bit_cnt_q  <= '0;
              ack_slot_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign start_out      = start_q;
  assign stop_out       = stop_q;
  assign scl_rise_out   = rise_q;
  assign scl_fall_out   = fall_q;
  assign byte_out       = byte_q;
  assign byte_valid_out = byte_valid_q;
  assign ack_slot_out   = ack_slot_q;
  assign ack_bit_out    = ack_bit_q;
  assign bit_cnt_out    = bit_cnt_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_i2c_rx_front.sv
// Scoreboard bench for i2c_rx_front: stimulus pushes expected bus events,
// a negedge monitor pops and compares them as the DUT reports them.
module tb_i2c_rx_front;

  localparam int Q       = 8;
  localparam int EvStart = 0;
  localparam int EvStop  = 1;
  localparam int EvByte  = 2;
  localparam int EvAck   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       start_out, stop_out, scl_rise_out, scl_fall_out;
  logic [7:0] byte_out;
  logic       byte_valid_out, ack_slot_out, ack_bit_out, busy_out;
  logic [3:0] bit_cnt_out;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  logic ack_prev = 1'b0;

  always #5 clk = ~clk;

  i2c_rx_front #(.SYNC_STAGES(2), .FILT_LEN(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .scl_in         (scl),
    .sda_in         (sda),
    .start_out      (start_out),
    .stop_out       (stop_out),
    .scl_rise_out   (scl_rise_out),
    .scl_fall_out   (scl_fall_out),
    .byte_out       (byte_out),
    .byte_valid_out (byte_valid_out),
    .ack_slot_out   (ack_slot_out),
    .ack_bit_out    (ack_bit_out),
    .bit_cnt_out    (bit_cnt_out),
    .busy_out       (busy_out)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      EvStart: return "START";
      EvStop:  return "STOP";
      EvByte:  return "BYTE";
      default: return "ACK";
    endcase
  endfunction

  task automatic expect_ev(input int k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int k, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s %0h expected none", kname(k), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d) begin
        n_fail++;
        $display("FAIL event: got %s %0h expected %s %0h", kname(k), d, kname(e.kind), e.data);
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (start_out) got_ev(EvStart, 8'h00);
    if (stop_out) got_ev(EvStop, 8'h00);
    if (byte_valid_out) begin
      got_ev(EvByte, byte_out);
      check("bit_cnt_with_byte_valid", 32'(bit_cnt_out), 32'd8);
      check("scl_rise_with_byte_valid", 32'(scl_rise_out), 32'd1);
    end
    if (!ack_prev && ack_slot_out) check("ack_slot_rise_with_scl_fall", 32'(scl_fall_out), 32'd1);
    if (ack_prev && !ack_slot_out && rst_n) begin
      got_ev(EvAck, {7'b0, ack_bit_out});
      check("ack_slot_fall_with_scl_fall", 32'(scl_fall_out), 32'd1);
    end
    ack_prev = ack_slot_out;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pulses"}, 32'({start_out, stop_out, scl_rise_out, scl_fall_out, byte_valid_out}),
          32'd0);
    check({tag, "_byte_out"}, 32'(byte_out), 32'h00);
    check({tag, "_ack_slot"}, 32'(ack_slot_out), 32'd0);
    check({tag, "_ack_bit"}, 32'(ack_bit_out), 32'd1);
    check({tag, "_bit_cnt"}, 32'(bit_cnt_out), 32'd0);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
  endtask

  task automatic do_start;
    sda = 1'b0;
    wait_cyc(Q);
    scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic do_rep_start;
    sda = 1'b1;
    wait_cyc(Q);
    scl = 1'b1;
    wait_cyc(Q);
    sda = 1'b0;
    wait_cyc(Q);
    scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic do_stop;
    sda = 1'b0;
    wait_cyc(Q);
    scl = 1'b1;
    wait_cyc(Q);
    sda = 1'b1;
    wait_cyc(2 * Q);
  endtask

  task automatic send_bit(input logic b, input bit ack_chk);
    sda = b;
    wait_cyc(Q);
    if (ack_chk) check("ack_slot_low_phase", 32'(ack_slot_out), 32'd1);
    scl = 1'b1;
    wait_cyc(Q);
    if (ack_chk) check("ack_slot_high_phase", 32'(ack_slot_out), 32'd1);
    wait_cyc(Q);
    scl = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
    send_bit(ack, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    check_reset("reset");
    rst_n = 1'b1;
    wait_cyc(10);

    // SCL activity without START must not wake the receiver.
    for (int i = 0; i < 20; i++) begin
      scl = ~scl;
      wait_cyc(Q);
    end
    check("idle_toggles_busy", 32'(busy_out), 32'd0);
    check("idle_toggles_bit_cnt", 32'(bit_cnt_out), 32'd0);

    // START, A5 with ACK, STOP.
    expect_ev(EvStart, 8'h00);
    expect_ev(EvByte, 8'hA5);
    expect_ev(EvAck, 8'h00);
    expect_ev(EvStop, 8'h00);
    do_start;
    check("busy_after_start", 32'(busy_out), 32'd1);
    send_byte(8'hA5, 1'b0);
    check("ack_bit_ack", 32'(ack_bit_out), 32'd0);
    do_stop;
    check("busy_after_stop", 32'(busy_out), 32'd0);
    wait_cyc(10);

    // Glitch shorter than the filter window, then one exactly as long.
    sda = 1'b0;
    wait_cyc(2);
    sda = 1'b1;
    wait_cyc(20);
    check("glitch2_busy", 32'(busy_out), 32'd0);
    expect_ev(EvStart, 8'h00);
    expect_ev(EvStop, 8'h00);
    sda = 1'b0;
    wait_cyc(3);
    sda = 1'b1;
    wait_cyc(20);
    check("glitch3_busy_after_stop", 32'(busy_out), 32'd0);

    // Partial byte cut by repeated START, then 3C.
    expect_ev(EvStart, 8'h00);
    do_start;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("bit_cnt_partial5", 32'(bit_cnt_out), 32'd5);
    expect_ev(EvStart, 8'h00);
    do_rep_start;
    check("bit_cnt_after_rstart", 32'(bit_cnt_out), 32'd0);
    check("busy_after_rstart", 32'(busy_out), 32'd1);
    expect_ev(EvByte, 8'h3C);
    expect_ev(EvAck, 8'h00);
    expect_ev(EvStop, 8'h00);
    send_byte(8'h3C, 1'b0);
    do_stop;

    // NACK, then STOP after 3 bits.
    expect_ev(EvStart, 8'h00);
    expect_ev(EvByte, 8'hC6);
    expect_ev(EvAck, 8'h01);
    expect_ev(EvStop, 8'h00);
    do_start;
    send_byte(8'hC6, 1'b1);
    check("ack_bit_nack", 32'(ack_bit_out), 32'd1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("bit_cnt_partial3", 32'(bit_cnt_out), 32'd3);
    do_stop;
    check("bit_cnt_after_stop", 32'(bit_cnt_out), 32'd0);
    check("busy_after_nack_stop", 32'(busy_out), 32'd0);
    check("byte_held_after_partial", 32'(byte_out), 32'hC6);

    // Asynchronous reset mid-byte.
    expect_ev(EvStart, 8'h00);
    do_start;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("bit_cnt_partial4", 32'(bit_cnt_out), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    scl = 1'b1;
    sda = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(10);
    check("busy_after_reset_release", 32'(busy_out), 32'd0);
    expect_ev(EvByte, 8'h81);
    expect_ev(EvAck, 8'h00);
    expect_ev(EvStop, 8'h00);
    exp_q.push_front('{kind: EvStart, data: 8'h00});
    do_start;
    send_byte(8'h81, 1'b0);
    do_stop;

    wait_cyc(20);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
